// File: rtl/fetch_queue_pkg.sv
// Shared types and sizing for the fetch queue.
//   fetch_entry_t : {pc, instr} pair held in the queue
//   FQ_DEPTH, FQ_XLEN, FQ_PTR_W : default sizing
package fetch_queue_pkg;

    localparam int unsigned FQ_DEPTH = 4;
    localparam int unsigned FQ_XLEN  = 32;
    localparam int unsigned FQ_PTR_W = $clog2(FQ_DEPTH);

    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch / instruction-memory / decode signal bundle around the fetch queue.
//   master : fetch, memory and decode side (drives fetch_valid, fetch_pc, flush, imem_rdata, dec_ready)
//   slave  : fetch queue (drives fetch_stall, imem_req, imem_addr, dec_valid, dec_pc, dec_instr)
interface fetch_queue_if #(
    parameter int unsigned XLEN = 32
);
    logic            fetch_valid;
    logic [XLEN-1:0] fetch_pc;
    logic            fetch_stall;
    logic            flush;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            dec_valid;
    logic            dec_ready;
    logic [XLEN-1:0] dec_pc;
    logic [XLEN-1:0] dec_instr;

    modport master (
        output fetch_valid, fetch_pc, flush, imem_rdata, dec_ready,
        input  fetch_stall, imem_req, imem_addr, dec_valid, dec_pc, dec_instr
    );

    modport slave (
        input  fetch_valid, fetch_pc, flush, imem_rdata, dec_ready,
        output fetch_stall, imem_req, imem_addr, dec_valid, dec_pc, dec_instr
    );
endinterface

// File: rtl/fetch_queue_fifo.sv
// DEPTH-entry circular FIFO of fetch_entry_t with synchronous clear.
//   clk, rst   : clock, asynchronous active-low reset
//   push, wr_data : write wr_data at tail
//   pop        : advance head
//   clear      : empty the FIFO (priority over push/pop)
//   count      : occupancy 0..DEPTH
//   head_data  : entry at head
module fetch_queue_fifo
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  fetch_entry_t     wr_data,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head_data
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    assign head_data = mem[head];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[tail] <= wr_data;
                tail      <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode queue: issues fetch PCs to a 1-cycle instruction memory,
// pairs each PC with its returned word, buffers the pairs and hands them to
// decode over valid/ready. Back-pressures fetch and squashes on flush.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : fetch_queue_if.slave (fetch, imem and decode signals)
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH,
    parameter int unsigned XLEN  = FQ_XLEN
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             inflight_valid;
    logic [XLEN-1:0]  inflight_pc;
    logic [CNT_W-1:0] count;
    fetch_entry_t     wr_data;
    fetch_entry_t     head_data;
    logic             issue;
    logic             push;
    logic             pop;

    // Stall reserves a slot for the read already in flight; registers only,
    // so a pop cannot release it in the same cycle.
    assign bus.fetch_stall = (count + CNT_W'(inflight_valid)) >= CNT_W'(DEPTH);

    // rst term keeps the strobe low while reset is held.
    assign issue         = rst & bus.fetch_valid & ~bus.fetch_stall & ~bus.flush;
    assign bus.imem_req  = issue;
    assign bus.imem_addr = bus.fetch_pc;

    assign bus.dec_valid = (count != '0) & ~bus.flush;
    assign pop           = bus.dec_valid & bus.dec_ready;
    assign push          = inflight_valid & ~bus.flush;

    assign wr_data.pc    = FQ_XLEN'(inflight_pc);
    assign wr_data.instr = FQ_XLEN'(bus.imem_rdata);
    assign bus.dec_pc    = XLEN'(head_data.pc);
    assign bus.dec_instr = XLEN'(head_data.instr);

    // One outstanding read tracked; its PC is paired with next cycle's data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_valid <= 1'b0;
            inflight_pc    <= '0;
        end else begin
            inflight_valid <= issue;
            if (issue) begin
                inflight_pc <= bus.fetch_pc;
            end
        end
    end

    fetch_queue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .clear     (bus.flush),
        .wr_data   (wr_data),
        .count     (count),
        .head_data (head_data)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised and directed bench for fetch_queue against a queue-based model.
module tb_fetch_queue;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    // Reference state
    ent_t        q[$];
    bit          infl;
    logic [31:0] infl_pc;
    logic [31:0] fpc;

    fetch_queue_if #(.XLEN(32)) bus ();

    fetch_queue #(.DEPTH(4), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] pc);
        return (pc * 32'd3) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        infl    = 1'b0;
        infl_pc = '0;
        fpc     = '0;
    endtask

    // Entered at posedge+2: drive inputs, compare at posedge+4, advance model.
    task automatic step(input bit fv, input bit fl, input logic [31:0] tgt, input bit rdy);
        bit          es, er, ev;
        logic [31:0] rdata;
        rdata           = infl ? mem_f(infl_pc) : 32'($urandom);
        bus.fetch_valid = fv;
        bus.fetch_pc    = fpc;
        bus.flush       = fl;
        bus.dec_ready   = rdy;
        bus.imem_rdata  = rdata;
        #2;
        es = (q.size() + int'(infl)) >= 4;
        er = fv && !es && !fl;
        ev = (q.size() != 0) && !fl;
        chk("fetch_stall", 32'(bus.fetch_stall), 32'(es));
        chk("imem_req", 32'(bus.imem_req), 32'(er));
        if (er) chk("imem_addr", bus.imem_addr, fpc);
        chk("dec_valid", 32'(bus.dec_valid), 32'(ev));
        if (ev) begin
            chk("dec_pc", bus.dec_pc, q[0].pc);
            chk("dec_instr", bus.dec_instr, q[0].instr);
        end
        if (fl) begin
            q.delete();
            infl = 1'b0;
            fpc  = tgt;
        end else begin
            if (ev && rdy) void'(q.pop_front());
            if (infl) q.push_back('{pc: infl_pc, instr: rdata});
            infl = er;
            if (er) begin
                infl_pc = fpc;
                fpc     = fpc + 32'd4;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Hold reset across two edges, release at posedge+2.
    task automatic hard_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst             = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.fetch_pc    = '0;
        bus.flush       = 1'b0;
        bus.dec_ready   = 1'b0;
        bus.imem_rdata  = '0;
        model_reset();
        #1;
        chk("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
        chk("rst_dec_pc", bus.dec_pc, 32'd0);
        chk("rst_dec_instr", bus.dec_instr, 32'd0);
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst_fetch_stall", 32'(bus.fetch_stall), 32'd0);
        hard_reset();

        // Streaming with decode always ready
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, '0, 1'b1);
            if (i == 0) chk("t1_req_cycle0", 32'(bus.imem_req), 32'd1);
            if (i >= 2 && i <= 4) begin
                chk("t1_dec_pc", bus.dec_pc, 32'(4 * (i - 2)));
                chk("t1_dec_instr", bus.dec_instr, mem_f(32'(4 * (i - 2))));
            end
            chk("t1_stall", 32'(bus.fetch_stall), 32'd0);
            tick();
        end

        // Fill with decode blocked, then drain in order
        hard_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            if (i < 4) chk("t2_drain_pc", bus.dec_pc, 32'(4 * i));
            if (i == 0) chk("t2_stall_held", 32'(bus.fetch_stall), 32'd1);
            if (i == 1) chk("t2_stall_release", 32'(bus.fetch_stall), 32'd0);
            if (i == 4) chk("t2_empty", 32'(bus.dec_valid), 32'd0);
            tick();
        end

        // Full FIFO with alternating pops and returning pushes, pointers wrap
        hard_reset();
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b0, '0, (i >= 6) && (i % 2 == 0));
            tick();
        end

        // Flush with 3 buffered plus 1 in flight
        hard_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            tick();
        end
        step(1'b1, 1'b1, 32'h100, 1'b1);
        chk("t4_flush_dec_valid", 32'(bus.dec_valid), 32'd0);
        tick();
        step(1'b1, 1'b0, '0, 1'b1);
        chk("t4_target_issue", bus.imem_addr, 32'h100);
        tick();
        step(1'b1, 1'b0, '0, 1'b1);
        chk("t4_no_stale", 32'(bus.dec_valid), 32'd0);
        tick();
        step(1'b1, 1'b0, '0, 1'b1);
        chk("t4_target_pc", bus.dec_pc, 32'h100);
        tick();

        // Asynchronous reset mid-stream
        hard_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            tick();
        end
        step(1'b1, 1'b0, '0, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        chk("t5_dec_valid", 32'(bus.dec_valid), 32'd0);
        chk("t5_dec_pc", bus.dec_pc, 32'd0);
        chk("t5_dec_instr", bus.dec_instr, 32'd0);
        chk("t5_imem_req", 32'(bus.imem_req), 32'd0);
        chk("t5_fetch_stall", 32'(bus.fetch_stall), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        step(1'b1, 1'b0, '0, 1'b1);
        chk("t5_restart_addr", bus.imem_addr, 32'd0);
        tick();

        // Flush coinciding with decode ready, 2 entries buffered
        hard_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            tick();
        end
        step(1'b0, 1'b1, 32'h200, 1'b1);
        chk("t6_flush_no_pop", 32'(bus.dec_valid), 32'd0);
        tick();
        step(1'b0, 1'b0, '0, 1'b1);
        chk("t6_empty_after", 32'(bus.dec_valid), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, '0, 1'b1);
            if (i == 2) chk("t6_target_pc", bus.dec_pc, 32'h200);
            tick();
        end

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) != 0, ($urandom % 20) == 0,
                 32'($urandom) & 32'hFFFF_FFFC, ($urandom % 2) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
